// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Multiplexed-display scan controller. Steps an active-low
//               one-hot anode drive through the digits enabled by
//               digit_mask at a fixed prescaled rate. It also exports the
//               active digit index and pulses frame_done on each scan wrap.
//               Optional feature macro: DISPLAY_SCAN_BLANK_EN. When defined,
//               it forces BLANK_CYCLES of dark anodes after every digit
//               change.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [N_DIGITS-1:0]         digit_mask,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic                        frame_done
);

  localparam int c_sel_w   = $clog2(N_DIGITS);
  localparam int c_presc_w = $clog2(REFRESH_DIV);

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);
  // Digit count widened by one bit so that index + offset cannot overflow.
  localparam logic [c_sel_w:0]     c_n_ext      = (c_sel_w + 1)'(N_DIGITS);

  logic [c_presc_w-1:0] r_presc;
  logic [c_sel_w-1:0]   r_digit_sel;
  logic [N_DIGITS-1:0]  r_an;
  logic                 r_frame_done;

  logic                 w_tick;
  logic [c_sel_w-1:0]   w_next_sel;
  logic                 w_found;
  logic [c_sel_w:0]     w_cand;
  logic [c_sel_w-1:0]   w_cand_idx;
  logic                 w_wrap;
  logic [N_DIGITS-1:0]  w_sel_hit;
  logic                 w_blank;
  logic [N_DIGITS-1:0]  w_an_next;

  assign w_tick = enable && (r_presc == c_presc_last);

  // Prescaler: counts 0..REFRESH_DIV-1 while enabled and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (enable) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // Circular search for the first enabled digit after the current one.
  // Offset N_DIGITS lands back on the current index. An empty mask finds
  // nothing, so the index holds.
  always_comb begin
    w_next_sel = r_digit_sel;
    w_found    = 1'b0;
    w_cand     = '0;
    w_cand_idx = '0;
    for (int k = 1; k <= N_DIGITS; k++) begin
      w_cand = {1'b0, r_digit_sel} + (c_sel_w + 1)'(k);
      if (w_cand >= c_n_ext) begin
        w_cand = w_cand - c_n_ext;
      end
      w_cand_idx = w_cand[c_sel_w-1:0];
      if (!w_found && digit_mask[w_cand_idx]) begin
        w_next_sel = w_cand_idx;
        w_found    = 1'b1;
      end
    end
  end

  // The scan wraps when the new index does not lie above the old one.
  assign w_wrap = (w_next_sel <= r_digit_sel) && (|digit_mask);

  // Digit index register: moves only on a prescaler tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit_sel <= '0;
    end else if (w_tick) begin
      r_digit_sel <= w_next_sel;
    end
  end

  // Frame pulse: set for the single cycle after a wrapping tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_tick && w_wrap;
    end
  end

  // Per-digit select decode. Because it is driven from a single registered
  // index, at most one bit can ever be set.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_hit
    assign w_sel_hit[gi] = digit_mask[gi] && (r_digit_sel == c_sel_w'(gi));
  end

`ifdef DISPLAY_SCAN_BLANK_EN
  localparam int c_blank_w = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);

  logic [c_blank_w-1:0] r_blank_cnt;

  // Dead-time counter: the tick cycle blanks the next cycle, and this
  // counter covers the remaining BLANK_CYCLES-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank_cnt <= '0;
    end else if (w_tick) begin
      r_blank_cnt <= c_blank_w'(BLANK_CYCLES - 1);
    end else if (r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - 1'b1;
    end
  end

  assign w_blank = (BLANK_CYCLES > 0) && (w_tick || (r_blank_cnt != '0));
`else
  // Dead time is compiled out, so BLANK_CYCLES has no effect here.
  assign w_blank = (BLANK_CYCLES < 0);
`endif

  assign w_an_next = (enable && !w_blank) ? ~w_sel_hit : '1;

  // Registered anode drive: all ones means dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an <= '1;
    end else begin
      r_an <= w_an_next;
    end
  end

  assign an         = r_an;
  assign digit_sel  = r_digit_sel;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl. It runs directed
//               vector tables, an asynchronous reset sequence, randomized
//               traffic against a reference model, and a 6-digit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int N   = 4;
  localparam int RD  = 4;
  localparam int BC  = 2;
  localparam int N6  = 6;
  localparam int RD6 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] digit_mask = '0;
  logic [3:0] an;
  logic [1:0] digit_sel;
  logic       frame_done;

  logic       rst6_n = 1'b0;
  logic       en6 = 1'b0;
  logic [5:0] mask6 = '0;
  logic [5:0] an6;
  logic [2:0] sel6;
  logic       fd6;

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_mask(digit_mask),
    .an(an), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  display_scan_ctrl #(.N_DIGITS(N6), .REFRESH_DIV(RD6), .BLANK_CYCLES(BC)) dut6 (
    .clk(clk), .rst_n(rst6_n), .enable(en6), .digit_mask(mask6),
    .an(an6), .digit_sel(sel6), .frame_done(fd6)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int         m_pre;
  int         m_sel;
  int         m_blank;
  logic [3:0] m_an;
  logic       m_fd;

  typedef struct {
    logic       en;
    logic [3:0] mask;
    int         cycles;
    logic [3:0] an_e;
    int         sel_e;
    logic       fd_e;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_digit(input int cur, input logic [3:0] m);
    for (int d = 1; d <= N; d++) begin
      if (m[(cur + d) % N]) return (cur + d) % N;
    end
    return cur;
  endfunction

  // One clock edge of the reference model, using the inputs held across that edge.
  task automatic model_step();
    bit tick;
    bit blank;
    int nsel;
    if (!rst_n) begin
      m_pre = 0; m_sel = 0; m_an = '1; m_fd = 1'b0; m_blank = 0;
      return;
    end
    tick  = enable && (m_pre == RD - 1);
    blank = 1'b0;
`ifdef DISPLAY_SCAN_BLANK_EN
    blank = tick || (m_blank > 0);
    if (tick) m_blank = BC - 1;
    else if (m_blank > 0) m_blank--;
`endif
    m_an = '1;
    if (enable && !blank && digit_mask[m_sel]) m_an[m_sel] = 1'b0;
    if (enable) m_pre = tick ? 0 : m_pre + 1;
    m_fd = 1'b0;
    if (tick && digit_mask != 4'b0000) begin
      nsel  = next_digit(m_sel, digit_mask);
      m_fd  = (nsel <= m_sel);
      m_sel = nsel;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("an", an, m_an);
    chk("digit_sel", digit_sel, m_sel);
    chk("frame_done", frame_done, m_fd);
    chk("an_onehot", $countones(~an) <= 1, 1);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      enable     = tbl[i].en;
      digit_mask = tbl[i].mask;
      repeat (tbl[i].cycles) cycle();
`ifndef DISPLAY_SCAN_BLANK_EN
      chk($sformatf("tbl%0d_an", i), an, tbl[i].an_e);
`endif
      chk($sformatf("tbl%0d_sel", i), digit_sel, tbl[i].sel_e);
      chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].fd_e);
    end
  endtask

  initial begin
    // Full mask scan, then a sparse mask, an empty mask, and a freeze.
    tbl[0]  = '{1'b1, 4'hF, 1,  4'hE, 0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 3,  4'hE, 1, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 1,  4'hD, 1, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 3,  4'hD, 2, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 4,  4'hB, 3, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4,  4'h7, 0, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 1,  4'hE, 0, 1'b0};
    tbl[7]  = '{1'b1, 4'h5, 3,  4'hE, 2, 1'b0};
    tbl[8]  = '{1'b1, 4'h5, 1,  4'hB, 2, 1'b0};
    tbl[9]  = '{1'b1, 4'h5, 3,  4'hB, 0, 1'b1};
    tbl[10] = '{1'b1, 4'h5, 1,  4'hE, 0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 1,  4'hF, 0, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 4,  4'hF, 0, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 6,  4'hD, 2, 1'b0};
    tbl[14] = '{1'b1, 4'hF, 2,  4'hB, 2, 1'b0};
    tbl[15] = '{1'b0, 4'hF, 10, 4'hF, 2, 1'b0};
    tbl[16] = '{1'b1, 4'hF, 1,  4'hB, 2, 1'b0};
    tbl[17] = '{1'b1, 4'hF, 1,  4'hB, 3, 1'b0};
    tbl[18] = '{1'b1, 4'hF, 1,  4'h7, 3, 1'b0};

    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) cycle();
    chk("reset_an", an, 4'hF);
    chk("reset_sel", digit_sel, 0);
    chk("reset_fd", frame_done, 0);
    rst_n = 1'b1;

    run_table(0, 18);

    // Asynchronous reset while digit 3 is lit, with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_step();
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_sel", digit_sel, 0);
    chk("async_rst_fd", frame_done, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    run_table(0, 6);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) digit_mask = 4'($urandom);
      enable = ($urandom_range(7) != 0);
      cycle();
    end

    // Six-digit instance with a non-power-of-two digit count.
    enable = 1'b1;
    digit_mask = 4'hF;
    mask6 = 6'b100001;
    en6 = 1'b1;
    rst6_n = 1'b1;
    repeat (3) cycle();
    chk("n6_sel_a", sel6, 5);
    chk("n6_an_a", an6, 6'b111110);
    chk("n6_fd_a", fd6, 0);
    cycle();
    chk("n6_an_b", an6, 6'b011111);
    repeat (2) cycle();
    chk("n6_sel_c", sel6, 0);
    chk("n6_fd_c", fd6, 1);
    cycle();
    chk("n6_fd_d", fd6, 0);
    chk("n6_an_d", an6, 6'b111110);
    for (int i = 0; i < 200; i++) begin
      if (i % 3 == 0) mask6 = 6'($urandom);
      cycle();
      chk("n6_range", sel6 < 3'd6, 1);
      chk("n6_onehot", $countones(~an6) <= 1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
